// File: rtl/bsg_fifo_1r1w_bypass_skid.sv
// bsg_fifo_1r1w_bypass_skid
// Two-entry ready/valid FIFO with a zero-latency bypass when empty.
// ready_o is registered, so there is no combinational path from yumi_i
// back to the producer. While the FIFO holds data, data_i is never
// forwarded, which keeps the stream in order.
module bsg_fifo_1r1w_bypass_skid #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    // Storage is never reset; only the bookkeeping below is.
    logic [width_p-1:0] mem_q [2];

    logic [1:0] count_q, count_d;
    logic       rptr_q,  rptr_d;
    logic       wptr_q,  wptr_d;
    logic       ready_q, ready_d;

    logic       empty;
    logic       enq;
    logic       deq;
    logic       pop;
    logic       wr_en;

    // Handshake decode: a word sent through the bypass is neither written nor popped.
    always_comb begin
        empty = (count_q == 2'd0);
        enq   = v_i & ready_q;
        deq   = yumi_i;
        pop   = deq & ~empty;
        wr_en = enq & ~(empty & deq);
    end

    // Next-state for pointers, occupancy and the registered ready.
    always_comb begin
        rptr_d  = rptr_q ^ pop;
        wptr_d  = wptr_q ^ wr_en;
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != 2'd2);
    end

    // Control state; async reset empties the FIFO and reopens the input.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= 2'd0;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            ready_q <= ready_d;
        end
    end

    // Data array write; held off during reset so nothing is recorded.
    always_ff @(posedge clk_i) begin
        if (wr_en & ~reset_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Output mux: bypass when empty, otherwise present the head entry.
    always_comb begin
        ready_o = ready_q;
        v_o     = empty ? v_i    : 1'b1;
        data_o  = empty ? data_i : mem_q[rptr_q];
    end

    // The consumer may only take a word that is actually offered.
    a_yumi_legal : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

    // A full FIFO must never advertise space, and occupancy never exceeds two.
    a_ready_full : assert property (@(posedge clk_i) disable iff (reset_i)
                                    (count_q != 2'd3) && !(ready_q && count_q == 2'd2));

endmodule

// File: doc/bsg_fifo_1r1w_bypass_skid.md
# bsg_fifo_1r1w_bypass_skid

Two-entry ready/valid FIFO with a zero-latency bypass path. It sits directly upstream of the enable-gated bypass register and produces the `v_o`/`data_o` stream that drives that register's `en_i`/`data_i`. When empty, a word flows through combinationally in the same cycle. When the consumer stalls, up to two words are captured so the producer sees a registered `ready_o` with no combinational path from `yumi_i`.

## Interface
- `width_p`, default 16: data word width in bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `v_i`  in  1  producer valid.
- `data_i`  in  `width_p`  producer data.
- `ready_o`  out  1  FIFO can accept a word this cycle. Registered; no combinational dependence on `yumi_i` or `v_i`.
- `v_o`  out  1  consumer-side valid.
- `data_o`  out  `width_p`  consumer-side data.
- `yumi_i`  in  1  consumer takes `data_o` this cycle. Legal only when `v_o`=1.

## Operation
- Storage: 2 entries `mem[0:1]`, 1-bit `rptr`, 1-bit `wptr`, 2-bit `count` (0..2).
- Enqueue condition: `enq = v_i & ready_o`.
- Dequeue condition: `deq = yumi_i`.
- Empty (`count`=0), bypass:
  - `v_o = v_i`, `data_o = data_i`.
  - `enq & deq`: the word passes through and is not written; count stays 0 and pointers do not move.
  - `enq & ~deq`: write `mem[wptr]`, `wptr` toggles, count becomes 1.
- Non-empty (`count` 1 or 2):
  - `v_o = 1`, `data_o = mem[rptr]`. `data_i` is never forwarded while the FIFO holds data, so order is preserved.
  - `deq`: `rptr` toggles.
  - `enq`: write `mem[wptr]`, `wptr` toggles.
  - Count update: `count += enq - deq`.
- `ready_o` register: next value is `next_count != 2`.
- Pointers wrap modulo 2.
- Full (`count`=2): `ready_o`=0 and `v_i` is ignored. A `deq` drops count to 1 and raises `ready_o` the next cycle.
- `count`=1 with `enq & deq`: count stays 1. The head advances to the new word next cycle.
- Protocol violation (`yumi_i`=1 while `v_o`=0): simulation assertion error. State is undefined.
- Reset, including mid-operation: asynchronously clears `count`, `rptr`, `wptr` and sets `ready_o`=1. Stored words are discarded and `mem` is not cleared.
  - While `reset_i`=1: `v_o = v_i`, `data_o = data_i` (empty bypass). Enqueue and dequeue are not recorded.
- Width rule: `data_o` is exactly `width_p` bits. No width conversion or zero-extension.

## Timing
- Latency when empty and `yumi_i` asserted: 0 cycles (combinational `data_i` -> `data_o`).
- Latency when buffered: the word appears on `data_o` the cycle after the enqueue edge, or later if older words are ahead.
- `ready_o` changes only on a clock edge or on asynchronous reset assertion.
- Reset values:
  - `ready_o`=1.
  - `v_o` follows `v_i`.
  - `data_o` follows `data_i`.
  - Internal `count`=0, `rptr`=0, `wptr`=0.
- Throughput: 1 word/cycle sustained with `yumi_i` held high.
- Combinational paths:
  - `v_i` -> `v_o` and `data_i` -> `data_o`: exist only via the empty-bypass mux.
  - `yumi_i` -> `ready_o`: none.

## Test plan
- Bypass: reset, then `v_i`=1, `data_i`=16'hA5A5, `yumi_i`=1 in one cycle. Same cycle `v_o`=1 and `data_o`=16'hA5A5; the following cycle count=0 and `ready_o`=1.
- Fill and stall: `yumi_i`=0; enqueue 16'h0001 then 16'h0002. After the second edge `ready_o`=0 and `data_o`=16'h0001. Offer 16'h0003: it is not accepted. Assert `yumi_i` for 2 cycles: `data_o` shows 16'h0001 then 16'h0002, and `ready_o`=1 after the first dequeue edge.
- Simultaneous enq/deq at count=1: hold 16'h0010. Enqueue 16'h0011 and dequeue in the same cycle: `data_o`=16'h0010 that cycle, 16'h0011 the next, count stays 1.
- Pointer wrap: stream 8 words (16'h0100..16'h0107) with `yumi_i` toggling 1,0,1,0,… The output order is exactly 16'h0100..16'h0107, with no loss or duplication across repeated `rptr`/`wptr` wraps.
- Reset mid-operation: with count=2, pulse `reset_i` asynchronously between edges. `ready_o`=1 immediately and `v_o` equals `v_i`=0. The first post-reset word 16'hBEEF bypasses, and no stale data ever appears.
- Random: constrained-random `v_i` and `yumi_i` (yumi only when `v_o`) over 10k cycles, checked against a scoreboard queue. `ready_o` must never be 1 while count=2.
